// File: rtl/sdio_dat_rx.sv
// rtl/sdio_dat_rx.sv - SD DAT-line block receiver: byte stream out, per-line CRC16 check
// Build macro SDIO_DAT_CRC_EN enables the per-line CRC16 generators and comparison.
module sdio_dat_rx #(
    parameter int BLOCK_BYTES = 512,
    parameter int TIMEOUT_SMP = 65535
) (
    input  logic       ctrl_clk,
    input  logic       rst_n,
    input  logic       i_sample,
    input  logic [3:0] sdio_data_i,
    input  logic       i_listen,
    input  logic       i_wide,
    output logic [7:0] o_byte,
    output logic       o_byte_vld,
    output logic       o_done,
    output logic       o_crc_ok,
    output logic       o_timeout,
    output logic       o_busy
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_START, S_DATA, S_CRC, S_END, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  dat_q, dat_d;
    logic        wide_q, wide_d;
    logic [3:0]  sub_cnt_q, sub_cnt_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  byte_q, byte_d;
    logic        byte_vld_q, byte_vld_d;
    logic        done_q, done_d;
    logic        crc_ok_q, crc_ok_d;
    logic        timeout_q, timeout_d;
    logic        busy_q, busy_d;

    logic [3:0]  act;
    logic        start_bit;
    logic        end_ok;
    logic        byte_last;
    logic [7:0]  shift_nx;
    logic [16:0] to_next;
    logic        to_hit;
    logic        arm_go;
    logic        data_stb;
    logic        crc_stb;
    logic        crc_match;

    assign act       = wide_q ? 4'hF : 4'h1;
    assign start_bit = wide_q ? (dat_q == 4'h0) : ~dat_q[0];
    assign end_ok    = wide_q ? (dat_q == 4'hF) : dat_q[0];
    assign byte_last = wide_q ? (sub_cnt_q == 4'd1) : (sub_cnt_q == 4'd7);
    assign shift_nx  = wide_q ? {shift_q[3:0], dat_q} : {shift_q[6:0], dat_q[0]};
    assign to_next   = {1'b0, to_cnt_q} + 17'd1;
    assign to_hit    = (to_next >= 17'(TIMEOUT_SMP));
    assign arm_go    = (state_q == S_IDLE) && i_listen;
    assign data_stb  = (state_q == S_DATA) && i_sample;
    assign crc_stb   = (state_q == S_CRC) && i_sample;

    always_comb begin
        state_d    = state_q;
        dat_d      = sdio_data_i;
        wide_d     = wide_q;
        sub_cnt_d  = sub_cnt_q;
        byte_cnt_d = byte_cnt_q;
        to_cnt_d   = to_cnt_q;
        shift_d    = shift_q;
        byte_d     = byte_q;
        byte_vld_d = 1'b0;
        done_d     = 1'b0;
        crc_ok_d   = crc_ok_q;
        timeout_d  = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (i_listen) begin
                    wide_d     = i_wide;
                    crc_ok_d   = 1'b0;
                    timeout_d  = 1'b0;
                    to_cnt_d   = '0;
                    sub_cnt_d  = '0;
                    byte_cnt_d = '0;
                    state_d    = S_WAIT_START;
                end
            end
            S_WAIT_START: begin
                if (i_sample) begin
                    if (start_bit) begin
                        state_d = S_DATA;
                    end else begin
                        to_cnt_d = (to_cnt_q == 16'hFFFF) ? to_cnt_q : to_cnt_q + 16'd1;
                        if (to_hit) begin
                            timeout_d = 1'b1;
                            crc_ok_d  = 1'b0;
                            done_d    = 1'b1;
                            state_d   = S_DONE;
                        end
                    end
                end
            end
            S_DATA: begin
                if (i_sample) begin
                    shift_d = shift_nx;
                    if (byte_last) begin
                        sub_cnt_d  = '0;
                        byte_d     = shift_nx;
                        byte_vld_d = 1'b1;
                        if (byte_cnt_q == 11'(BLOCK_BYTES - 1)) begin
                            byte_cnt_d = '0;
                            state_d    = S_CRC;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 11'd1;
                        end
                    end else begin
                        sub_cnt_d = sub_cnt_q + 4'd1;
                    end
                end
            end
            S_CRC: begin
                // The 16 received CRC bits are consumed even when no CRC is checked.
                if (i_sample) begin
                    if (sub_cnt_q == 4'd15) begin
                        sub_cnt_d = '0;
                        state_d   = S_END;
                    end else begin
                        sub_cnt_d = sub_cnt_q + 4'd1;
                    end
                end
            end
            S_END: begin
                if (i_sample) begin
                    crc_ok_d = end_ok && crc_match;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge ctrl_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            dat_q      <= '0;
            wide_q     <= 1'b0;
            sub_cnt_q  <= '0;
            byte_cnt_q <= '0;
            to_cnt_q   <= '0;
            shift_q    <= '0;
            byte_q     <= '0;
            byte_vld_q <= 1'b0;
            done_q     <= 1'b0;
            crc_ok_q   <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dat_q      <= dat_d;
            wide_q     <= wide_d;
            sub_cnt_q  <= sub_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            to_cnt_q   <= to_cnt_d;
            shift_q    <= shift_d;
            byte_q     <= byte_d;
            byte_vld_q <= byte_vld_d;
            done_q     <= done_d;
            crc_ok_q   <= crc_ok_d;
            timeout_q  <= timeout_d;
            busy_q     <= busy_d;
        end
    end

`ifdef SDIO_DAT_CRC_EN
    logic [3:0][15:0] crc_q, crc_d;
    logic [3:0][15:0] rx_crc_q, rx_crc_d;

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ (((c[15] ^ b) == 1'b1) ? 16'h1021 : 16'h0000);
    endfunction

    always_comb begin
        crc_d     = crc_q;
        rx_crc_d  = rx_crc_q;
        crc_match = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (arm_go) begin
                crc_d[i]    = '0;
                rx_crc_d[i] = '0;
            end else if (act[i] && data_stb) begin
                crc_d[i] = crc16_step(crc_q[i], dat_q[i]);
            end else if (act[i] && crc_stb) begin
                rx_crc_d[i] = {rx_crc_q[i][14:0], dat_q[i]};
            end
            if (act[i] && (crc_q[i] != rx_crc_q[i])) begin
                crc_match = 1'b0;
            end
        end
    end

    always_ff @(posedge ctrl_clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q    <= '0;
            rx_crc_q <= '0;
        end else begin
            crc_q    <= crc_d;
            rx_crc_q <= rx_crc_d;
        end
    end
`else
    assign crc_match = 1'b1;
`endif

    assign o_byte     = byte_q;
    assign o_byte_vld = byte_vld_q;
    assign o_done     = done_q;
    assign o_crc_ok   = crc_ok_q;
    assign o_timeout  = timeout_q;
    assign o_busy     = busy_q;
endmodule

// File: tb/tb_sdio_dat_rx.sv
// tb/tb_sdio_dat_rx.sv - directed self-checking bench for sdio_dat_rx
module tb_sdio_dat_rx;
    localparam int NB = 512;
`ifdef SDIO_DAT_CRC_EN
    localparam logic CRC_BAD_EXP = 1'b0;
`else
    localparam logic CRC_BAD_EXP = 1'b1;
`endif

    logic       ctrl_clk;
    logic       rst_n;
    logic       i_sample;
    logic [3:0] sdio_data_i;
    logic       i_listen;
    logic       i_wide;
    logic [7:0] o_byte;
    logic       o_byte_vld;
    logic       o_done;
    logic       o_crc_ok;
    logic       o_timeout;
    logic       o_busy;

    int vectors;
    int errors;
    logic [7:0] rx_q[$];
    logic [7:0] blk[NB];

    sdio_dat_rx #(.BLOCK_BYTES(NB), .TIMEOUT_SMP(100)) dut (
        .ctrl_clk(ctrl_clk), .rst_n(rst_n), .i_sample(i_sample),
        .sdio_data_i(sdio_data_i), .i_listen(i_listen), .i_wide(i_wide),
        .o_byte(o_byte), .o_byte_vld(o_byte_vld), .o_done(o_done),
        .o_crc_ok(o_crc_ok), .o_timeout(o_timeout), .o_busy(o_busy)
    );

    initial ctrl_clk = 1'b0;
    always #5 ctrl_clk = ~ctrl_clk;

    always @(negedge ctrl_clk) begin
        if (o_byte_vld) rx_q.push_back(o_byte);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ctrl_clk);
        #1;
    endtask

    // Data is presented one cycle ahead of its strobe because the pad is registered.
    task automatic strobe(input logic [3:0] d, input int gap);
        sdio_data_i = d;
        tick();
        i_sample = 1'b1;
        tick();
        i_sample = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic arm(input logic w);
        i_wide   = w;
        i_listen = 1'b1;
        tick();
        i_listen = 1'b0;
    endtask

    function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ (((c[15] ^ b) == 1'b1) ? 16'h1021 : 16'h0000);
    endfunction

    task automatic send_block(input logic w, input int gap, input int idle,
                              input logic [3:0] crc_flip, input logic [3:0] end_val,
                              input int abort_at);
        logic [15:0] crc [4];
        logic [3:0]  nib;
        logic [2:0]  r;
        for (int l = 0; l < 4; l++) crc[l] = 16'h0000;
        repeat (idle) strobe(4'hF, gap);
        r = 3'($urandom);
        strobe(w ? 4'h0 : {r, 1'b0}, gap);
        for (int b = 0; b < NB; b++) begin
            if (b == abort_at) begin
                nib = blk[b][7:4];
                strobe(w ? nib : {r, nib[3]}, gap);
                return;
            end
            if (w) begin
                for (int h = 1; h >= 0; h--) begin
                    nib = blk[b][h*4 +: 4];
                    for (int l = 0; l < 4; l++) crc[l] = crc_bit(crc[l], nib[l]);
                    strobe(nib, gap);
                end
            end else begin
                for (int k = 7; k >= 0; k--) begin
                    r = 3'($urandom);
                    crc[0] = crc_bit(crc[0], blk[b][k]);
                    strobe({r, blk[b][k]}, gap);
                end
            end
        end
        for (int l = 0; l < 4; l++) crc[l][0] = crc[l][0] ^ crc_flip[l];
        for (int k = 15; k >= 0; k--) begin
            r = 3'($urandom);
            if (w) begin
                for (int l = 0; l < 4; l++) nib[l] = crc[l][k];
            end else begin
                nib = {r, crc[0][k]};
            end
            strobe(nib, gap);
        end
        r = 3'($urandom);
        strobe(w ? end_val : {r, end_val[0]}, 0);
    endtask

    task automatic check_done(input logic exp_ok, input logic exp_to, input logic listen_at_done);
        check("done_pulse", o_done, 1);
        check("crc_ok", o_crc_ok, exp_ok);
        check("timeout", o_timeout, exp_to);
        check("busy_at_done", o_busy, 1);
        i_listen = listen_at_done;
        tick();
        i_listen = 1'b0;
        check("done_one_cycle", o_done, 0);
        check("busy_fall", o_busy, 0);
    endtask

    task automatic check_bytes(input int n);
        int bad;
        bad = 0;
        check("byte_count", rx_q.size(), n);
        for (int i = 0; i < rx_q.size() && i < n; i++) begin
            if (rx_q[i] !== blk[i]) bad++;
        end
        check("byte_data_errors", bad, 0);
        if (n > 0) check("byte_hold", o_byte, blk[n-1]);
        rx_q.delete();
    endtask

    initial begin
        vectors     = 0;
        errors      = 0;
        rst_n       = 1'b0;
        i_sample    = 1'b0;
        i_listen    = 1'b0;
        i_wide      = 1'b0;
        sdio_data_i = 4'hF;
        repeat (3) tick();
        check("rst_byte", o_byte, 0);
        check("rst_vld", o_byte_vld, 0);
        check("rst_done", o_done, 0);
        check("rst_crc_ok", o_crc_ok, 0);
        check("rst_timeout", o_timeout, 0);
        check("rst_busy", o_busy, 0);
        rst_n = 1'b1;
        tick();

        // 4-bit read, strobe every 4 cycles
        for (int b = 0; b < NB; b++) blk[b] = 8'(b);
        arm(1'b1);
        check("busy_rise", o_busy, 1);
        send_block(1'b1, 2, 3, 4'h0, 4'hF, -1);
        check_done(1'b1, 1'b0, 1'b0);
        check_bytes(NB);

        // DAT2 CRC bit 0 inverted; i_listen on the o_done cycle must be ignored
        arm(1'b1);
        send_block(1'b1, 0, 2, 4'b0100, 4'hF, -1);
        check_done(CRC_BAD_EXP, 1'b0, 1'b1);
        tick();
        check("arm_on_done_ignored", o_busy, 0);
        check("status_kept", o_crc_ok, CRC_BAD_EXP);
        check_bytes(NB);

        // DAT1 low during END, then re-arm on the cycle after o_done
        arm(1'b1);
        send_block(1'b1, 0, 1, 4'h0, 4'hD, -1);
        check_done(1'b0, 1'b0, 1'b0);
        check_bytes(NB);
        arm(1'b1);
        check("rearm_accepted", o_busy, 1);

        // Timeout with DAT held high
        repeat (99) strobe(4'hF, 0);
        check("no_done_99", o_done, 0);
        check("busy_99", o_busy, 1);
        strobe(4'hF, 0);
        check_done(1'b0, 1'b1, 1'b0);
        check_bytes(0);

        // 1-bit read with noise on DAT[3:1]
        for (int b = 0; b < NB; b++) blk[b] = 8'hA5;
        arm(1'b0);
        check("arm_clears_timeout", o_timeout, 0);
        send_block(1'b0, 0, 1, 4'h0, 4'hF, -1);
        check_done(1'b1, 1'b0, 1'b0);
        check_bytes(NB);

        // Reset after byte 100
        for (int b = 0; b < NB; b++) blk[b] = 8'(b * 7 + 3);
        arm(1'b1);
        send_block(1'b1, 0, 1, 4'h0, 4'hF, 100);
        check_bytes(100);
        rst_n = 1'b0;
        #1;
        check("mid_rst_byte", o_byte, 0);
        check("mid_rst_vld", o_byte_vld, 0);
        check("mid_rst_done", o_done, 0);
        check("mid_rst_crc_ok", o_crc_ok, 0);
        check("mid_rst_timeout", o_timeout, 0);
        check("mid_rst_busy", o_busy, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_no_done", o_done, 0);
        check_bytes(0);

        // Clean read whose start bit lands on the strobe that would hit the limit
        for (int b = 0; b < NB; b++) blk[b] = 8'(255 - (b % 256));
        arm(1'b1);
        send_block(1'b1, 0, 99, 4'h0, 4'hF, -1);
        check_done(1'b1, 1'b0, 1'b0);
        check_bytes(NB);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
